// File: rtl/clus_sim_pkg.sv
// Shared types and constants for the cluster simulation pattern generators.
// Holds payload-mode and FSM encodings, LFSR constants and the 5/A fill words.
package clus_sim_pkg;

    typedef enum logic [1:0] {
        MODE_CNT  = 2'b00,
        MODE_ALT  = 2'b01,
        MODE_WALK = 2'b10,
        MODE_LFSR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_HEADER  = 2'b01,
        ST_PAYLOAD = 2'b10,
        ST_DONE    = 2'b11
    } state_e;

    // Galois taps for x^32+x^22+x^2+x+1 in a right-shifting register
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

    localparam logic [31:0] PAT_5 = 32'h5555_5555;
    localparam logic [31:0] PAT_A = 32'hAAAA_AAAA;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/clus_pattern_word_gen.sv
// Payload word source: counter, 5/A alternate, walking-one and LFSR generators.
// Ports: mode, word_idx, advance, event_start, spill_clear, keep in; word out.
module clus_pattern_word_gen
    import clus_sim_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 13
) (
    input  logic              fifoclk,
    input  logic              fifoclk_resetn,
    input  logic [1:0]        mode,
    input  logic [IDX_W-1:0]  word_idx,
    input  logic              advance,
    input  logic              event_start,
    input  logic              spill_clear,
    input  logic              keep,
    output logic [DATA_W-1:0] word
);

    localparam int REP = (DATA_W + 31) / 32;

    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic              alt_q, alt_d;
    logic [DATA_W-1:0] pat5;
    logic [DATA_W-1:0] pata;
    logic [DATA_W-1:0] one;
    logic [IDX_W-1:0]  walk_sh;
    mode_e             mode_sel;

    assign pat5     = DATA_W'({REP{PAT_5}});
    assign pata     = DATA_W'({REP{PAT_A}});
    assign one      = DATA_W'(1);
    assign walk_sh  = word_idx % IDX_W'(DATA_W);
    assign mode_sel = mode_e'(mode);

    // Each generator only moves when its own mode is selected, so the
    // counter and LFSR sequences stay continuous across events of that mode.
    always_comb begin
        cnt_d  = cnt_q;
        lfsr_d = lfsr_q;
        alt_d  = alt_q;
        if (spill_clear) begin
            alt_d = 1'b0;
            if (!keep) begin
                cnt_d  = '0;
                lfsr_d = LFSR_SEED;
            end
        end else begin
            if (advance) begin
                case (mode_sel)
                    MODE_CNT:  cnt_d  = cnt_q + DATA_W'(1);
                    MODE_ALT:  alt_d  = ~alt_q;
                    MODE_LFSR: lfsr_d = lfsr_next(lfsr_q);
                    default:   ;
                endcase
            end
            if (event_start) begin
                alt_d = 1'b0;
            end
        end
    end

    always_comb begin
        case (mode_sel)
            MODE_CNT:  word = cnt_q;
            MODE_ALT:  word = alt_q ? pata : pat5;
            MODE_WALK: word = one << walk_sh;
            default:   word = DATA_W'(lfsr_q);
        endcase
    end

    always_ff @(posedge fifoclk or negedge fifoclk_resetn) begin
        if (!fifoclk_resetn) begin
            cnt_q  <= '0;
            lfsr_q <= LFSR_SEED;
            alt_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lfsr_q <= lfsr_d;
            alt_q  <= alt_d;
        end
    end

endmodule

// File: rtl/clus_pattern_gen_mc.sv
// Multi-lane event pattern generator: header plus fixed-size payload per event.
// Ports: init/mode/lane_en/fifo_full/hit/tag in; per-lane we+data, busy, size_ovfl, ev_cnt out.
module clus_pattern_gen_mc
    import clus_sim_pkg::*;
#(
    parameter int NLANES        = 4,
    parameter int DATA_W        = 32,
    parameter int TAG_W         = 20,
    parameter int SIZE_W        = 12,
    parameter int HIT_W         = 10,
    parameter int WORDS_PER_HIT = 8
) (
    input  logic                     fifoclk,
    input  logic                     fifoclk_resetn,
    input  logic                     newspill_reset,
    input  logic                     haltrun_en,
    input  logic                     pattern_init,
    input  logic [1:0]               pattern_mode,
    input  logic [NLANES-1:0]        lane_en,
    input  logic [NLANES-1:0]        fifo_full,
    input  logic [HIT_W-1:0]         hit_in,
    input  logic [TAG_W-1:0]         ewtag_in,
    output logic [NLANES-1:0]        pattern_we,
    output logic [NLANES*DATA_W-1:0] pattern_data,
    output logic                     busy,
    output logic                     size_ovfl,
    output logic [15:0]              ev_cnt
);

    localparam int WPH_LOG = $clog2(WORDS_PER_HIT);
    localparam int IDX_W   = HIT_W + WPH_LOG;

    state_e                  state_q, state_d;
    logic [HIT_W-1:0]        hits_q, hits_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic [1:0]              mode_q, mode_d;
    logic [NLANES-1:0]       lanes_q, lanes_d;
    logic [IDX_W-1:0]        wcnt_q, wcnt_d;
    logic [NLANES-1:0]       we_q, we_d;
    logic [NLANES*DATA_W-1:0] data_q, data_d;
    logic                    ovfl_q, ovfl_d;
    logic [15:0]             ev_q, ev_d;

    logic                    stall;
    logic                    issue;
    logic                    advance;
    logic                    ev_start;
    logic [DATA_W-1:0]       word_sel;
    logic [DATA_W-1:0]       gen_word;
    logic [DATA_W-1:0]       hdr_word;
    logic [HIT_W:0]          dbl;
    logic                    size_over;
    logic [SIZE_W-1:0]       size_val;
    logic [IDX_W-1:0]        last_idx;

    clus_pattern_word_gen #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_word_gen (
        .fifoclk        (fifoclk),
        .fifoclk_resetn (fifoclk_resetn),
        .mode           (mode_q),
        .word_idx       (wcnt_q),
        .advance        (advance),
        .event_start    (ev_start),
        .spill_clear    (newspill_reset),
        .keep           (haltrun_en),
        .word           (gen_word)
    );

    // Full flags of lanes not taking part in this event are ignored
    assign stall = |(fifo_full & lanes_q);

    // Size is computed one bit wider than hits so saturation is exact
    assign dbl       = {hits_q, 1'b0};
    assign size_over = (SIZE_W < HIT_W + 1) && ((dbl >> SIZE_W) != '0);
    assign size_val  = size_over ? '1 : SIZE_W'(dbl);
    assign hdr_word  = (DATA_W'(size_val) << (DATA_W - SIZE_W))
                     | DATA_W'(tag_q);
    assign last_idx  = (IDX_W'(hits_q) << WPH_LOG) - IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        hits_d   = hits_q;
        tag_d    = tag_q;
        mode_d   = mode_q;
        lanes_d  = lanes_q;
        wcnt_d   = wcnt_q;
        ovfl_d   = ovfl_q;
        ev_d     = ev_q;
        we_d     = '0;
        data_d   = '0;
        issue    = 1'b0;
        advance  = 1'b0;
        ev_start = 1'b0;
        word_sel = '0;
        if (newspill_reset) begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
            ovfl_d  = 1'b0;
            if (!haltrun_en) begin
                ev_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pattern_init) begin
                        hits_d  = hit_in;
                        tag_d   = ewtag_in;
                        mode_d  = pattern_mode;
                        lanes_d = lane_en;
                        state_d = ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (!stall) begin
                        issue    = 1'b1;
                        word_sel = hdr_word;
                        if (size_over) begin
                            ovfl_d = 1'b1;
                        end
                        state_d = (hits_q != '0) ? ST_PAYLOAD : ST_DONE;
                    end
                end
                ST_PAYLOAD: begin
                    if (!stall) begin
                        issue    = 1'b1;
                        advance  = 1'b1;
                        word_sel = gen_word;
                        wcnt_d   = wcnt_q + IDX_W'(1);
                        if (wcnt_q == last_idx) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                    ev_d     = ev_q + 16'd1;
                    wcnt_d   = '0;
                    ev_start = 1'b1;
                    state_d  = ST_IDLE;
                end
            endcase
        end
        if (issue) begin
            we_d = lanes_q;
            for (int l = 0; l < NLANES; l++) begin
                data_d[l*DATA_W +: DATA_W] = lanes_q[l] ? word_sel : '0;
            end
        end
    end

    always_ff @(posedge fifoclk or negedge fifoclk_resetn) begin
        if (!fifoclk_resetn) begin
            state_q <= ST_IDLE;
            hits_q  <= '0;
            tag_q   <= '0;
            mode_q  <= '0;
            lanes_q <= '0;
            wcnt_q  <= '0;
            we_q    <= '0;
            data_q  <= '0;
            ovfl_q  <= 1'b0;
            ev_q    <= '0;
        end else begin
            state_q <= state_d;
            hits_q  <= hits_d;
            tag_q   <= tag_d;
            mode_q  <= mode_d;
            lanes_q <= lanes_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            data_q  <= data_d;
            ovfl_q  <= ovfl_d;
            ev_q    <= ev_d;
        end
    end

    assign pattern_we   = we_q;
    assign pattern_data = data_q;
    assign busy         = (state_q != ST_IDLE);
    assign size_ovfl    = ovfl_q;
    assign ev_cnt       = ev_q;

endmodule

// File: tb/tb_clus_pattern_gen_mc.sv
// Scoreboard bench for clus_pattern_gen_mc with a second SIZE_W=10 instance.
// Expected writes come from an event-level model; a monitor pops and compares.
module tb_clus_pattern_gen_mc;

    localparam int NL  = 4;
    localparam int DW  = 32;
    localparam int TW  = 20;
    localparam int SW  = 12;
    localparam int HW  = 10;
    localparam int WPH = 8;

    logic              fifoclk = 1'b0;
    logic              fifoclk_resetn;
    logic              newspill_reset;
    logic              haltrun_en;
    logic              pattern_init;
    logic [1:0]        pattern_mode;
    logic [NL-1:0]     lane_en;
    logic [NL-1:0]     fifo_full;
    logic [HW-1:0]     hit_in;
    logic [TW-1:0]     ewtag_in;
    logic [NL-1:0]     pattern_we;
    logic [NL*DW-1:0]  pattern_data;
    logic              busy;
    logic              size_ovfl;
    logic [15:0]       ev_cnt;
    logic [NL-1:0]     d2_we;
    logic [NL*DW-1:0]  d2_data;
    logic              d2_busy;
    logic              d2_ovfl;
    logic [15:0]       d2_ev;

    typedef struct {
        logic [NL-1:0]    we;
        logic [NL*DW-1:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] m_cnt;
    logic [31:0] m_lfsr;
    logic [15:0] m_ev;
    logic [31:0] d2_hdr;

    always #5 fifoclk = ~fifoclk;

    clus_pattern_gen_mc dut (
        .fifoclk        (fifoclk),
        .fifoclk_resetn (fifoclk_resetn),
        .newspill_reset (newspill_reset),
        .haltrun_en     (haltrun_en),
        .pattern_init   (pattern_init),
        .pattern_mode   (pattern_mode),
        .lane_en        (lane_en),
        .fifo_full      (fifo_full),
        .hit_in         (hit_in),
        .ewtag_in       (ewtag_in),
        .pattern_we     (pattern_we),
        .pattern_data   (pattern_data),
        .busy           (busy),
        .size_ovfl      (size_ovfl),
        .ev_cnt         (ev_cnt)
    );

    clus_pattern_gen_mc #(.SIZE_W(10)) dut2 (
        .fifoclk        (fifoclk),
        .fifoclk_resetn (fifoclk_resetn),
        .newspill_reset (newspill_reset),
        .haltrun_en     (haltrun_en),
        .pattern_init   (pattern_init),
        .pattern_mode   (pattern_mode),
        .lane_en        (lane_en),
        .fifo_full      (fifo_full),
        .hit_in         (hit_in),
        .ewtag_in       (ewtag_in),
        .pattern_we     (d2_we),
        .pattern_data   (d2_data),
        .busy           (d2_busy),
        .size_ovfl      (d2_ovfl),
        .ev_cnt         (d2_ev)
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // x^32+x^22+x^2+x+1: shift right, fold the output bit back into the taps
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic fb;
        fb = s[0];
        s  = s >> 1;
        if (fb) s = s ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
        return s;
    endfunction

    task automatic push_exp(input logic [NL-1:0] ln, input logic [31:0] w);
        exp_t e;
        if (ln != '0) begin
            e.we = ln;
            for (int l = 0; l < NL; l++)
                e.data[l*DW +: DW] = ln[l] ? w : 32'h0;
            sb.push_back(e);
        end
    endtask

    always @(negedge fifoclk) begin
        exp_t e;
        if (fifoclk_resetn && pattern_we != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {124'h0, pattern_we}, 128'h0);
            end else begin
                e = sb.pop_front();
                chk("write_we", {124'h0, pattern_we}, {124'h0, e.we});
                chk("write_data", pattern_data, e.data);
            end
        end
    end

    task automatic model_spill(input bit halt);
        if (!halt) begin
            m_cnt  = 32'h0;
            m_lfsr = 32'h1;
            m_ev   = 16'h0;
        end
    endtask

    task automatic spill(input bit halt);
        haltrun_en     = halt;
        newspill_reset = 1'b1;
        @(negedge fifoclk);
        newspill_reset = 1'b0;
        model_spill(halt);
    endtask

    task automatic run_event(input int h, input logic [TW-1:0] tag,
                             input logic [1:0] m, input logic [NL-1:0] ln,
                             input int init_len, input int abort_at,
                             input bit halt, input int st_at, input int st_len,
                             input logic [NL-1:0] st_mask, input bit rnd);
        int          n;
        int          c;
        int          exp_len;
        logic [31:0] w;
        logic [11:0] sz;
        n  = h * WPH;
        sz = (h * 2 > 4095) ? 12'hFFF : 12'(h * 2);
        push_exp(ln, {sz, tag});
        for (int i = 0; i < n; i++) begin
            if (abort_at >= 0 && i >= abort_at) break;
            case (m)
                2'b00: begin w = m_cnt; m_cnt = m_cnt + 1; end
                2'b01: w = (i % 2 == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
                2'b10: w = 32'h1 << (i % 32);
                default: begin w = m_lfsr; m_lfsr = lfsr_step(m_lfsr); end
            endcase
            push_exp(ln, w);
        end
        exp_len = n + 2 + (((st_mask & ln) != '0) ? st_len : 0);
        hit_in       = HW'(h);
        ewtag_in     = tag;
        pattern_mode = m;
        lane_en      = ln;
        pattern_init = 1'b1;
        c = 0;
        forever begin
            @(negedge fifoclk);
            c++;
            if (c == init_len) pattern_init = 1'b0;
            if (c == 2) d2_hdr = d2_data[31:0];
            if (rnd) begin
                fifo_full = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '0;
            end else if (st_at >= 0) begin
                if ((st_mask & ln) != '0 && c > st_at && c <= st_at + st_len)
                    chk("stall_no_we", {124'h0, pattern_we}, 128'h0);
                if (c == st_at) fifo_full = st_mask;
                if (c == st_at + st_len) fifo_full = '0;
            end
            if (abort_at >= 0 && c == abort_at + 2) begin
                haltrun_en     = halt;
                newspill_reset = 1'b1;
                @(negedge fifoclk);
                newspill_reset = 1'b0;
                model_spill(halt);
                break;
            end
            if (c > 1 && !busy) break;
            if (c > 20000) begin
                chk("event_timeout", {127'h0, busy}, 128'h0);
                break;
            end
        end
        pattern_init = 1'b0;
        fifo_full    = '0;
        if (abort_at < 0) begin
            m_ev = m_ev + 1;
            if (!rnd) chk("event_len", 128'(c - 1), 128'(exp_len));
        end else begin
            @(negedge fifoclk);
            chk("abort_idle", {127'h0, busy}, 128'h0);
            chk("abort_ovfl", {127'h0, size_ovfl}, 128'h0);
        end
        chk("sb_empty", 128'(sb.size()), 128'h0);
        chk("ev_cnt", {112'h0, ev_cnt}, {112'h0, m_ev});
    endtask

    initial begin
        fifoclk_resetn = 1'b0;
        newspill_reset = 1'b0;
        haltrun_en     = 1'b0;
        pattern_init   = 1'b0;
        pattern_mode   = 2'b00;
        lane_en        = '0;
        fifo_full      = '0;
        hit_in         = '0;
        ewtag_in       = '0;
        m_cnt          = 32'h0;
        m_lfsr         = 32'h1;
        m_ev           = 16'h0;
        d2_hdr         = 32'h0;
        repeat (3) @(negedge fifoclk);
        chk("rst_we", {124'h0, pattern_we}, 128'h0);
        chk("rst_data", pattern_data, 128'h0);
        chk("rst_busy", {127'h0, busy}, 128'h0);
        chk("rst_ovfl", {127'h0, size_ovfl}, 128'h0);
        chk("rst_ev", {112'h0, ev_cnt}, 128'h0);
        fifoclk_resetn = 1'b1;
        @(negedge fifoclk);

        // counter: 2 hits, then a follow-on event continuing at 16
        run_event(2, 20'h00005, 2'b00, 4'hF, 1, -1, 0, -1, 0, 4'h0, 0);
        run_event(1, 20'h00006, 2'b00, 4'h5, 1, -1, 0, -1, 0, 4'h0, 0);
        // alternate, walking-one, LFSR
        run_event(1, 20'h00010, 2'b01, 4'hF, 1, -1, 0, -1, 0, 4'h0, 0);
        run_event(5, 20'h00011, 2'b10, 4'hF, 1, -1, 0, -1, 0, 4'h0, 0);
        run_event(1, 20'h00012, 2'b11, 4'hF, 1, -1, 0, -1, 0, 4'h0, 0);
        // stall on an enabled lane, then full on a disabled lane
        run_event(2, 20'h00020, 2'b00, 4'hF, 1, -1, 0, 4, 5, 4'b0100, 0);
        run_event(2, 20'h00021, 2'b00, 4'b1011, 1, -1, 0, 2, 8, 4'b0100, 0);
        // zero hits with a held init, and an event with no lanes enabled
        run_event(0, 20'h00030, 2'b00, 4'hF, 3, -1, 0, -1, 0, 4'h0, 0);
        run_event(1, 20'h00031, 2'b00, 4'h0, 1, -1, 0, -1, 0, 4'h0, 0);
        chk("d2_no_ovfl", {127'h0, d2_ovfl}, 128'h0);

        // size saturation on the narrow-size instance only
        run_event(10'h200, 20'hABCDE, 2'b00, 4'hF, 1, -1, 0, -1, 0, 4'h0, 0);
        chk("d2_hdr", {96'h0, d2_hdr}, {96'h0, 10'h3FF, 2'b00, 20'hABCDE});
        chk("d2_ovfl_set", {127'h0, d2_ovfl}, 128'h1);
        chk("ovfl_clear", {127'h0, size_ovfl}, 128'h0);
        run_event(10'h3FF, 20'h12345, 2'b00, 4'hF, 1, -1, 0, -1, 0, 4'h0, 0);
        chk("ovfl_max", {127'h0, size_ovfl}, 128'h0);
        spill(1'b1);
        chk("d2_ovfl_spill", {127'h0, d2_ovfl}, 128'h0);

        // spill abort mid-payload at counter 37, keep then clear
        spill(1'b0);
        chk("spill_ev", {112'h0, ev_cnt}, 128'h0);
        run_event(5, 20'h00040, 2'b00, 4'hF, 1, 37, 1, -1, 0, 4'h0, 0);
        run_event(1, 20'h00041, 2'b00, 4'hF, 1, -1, 0, -1, 0, 4'h0, 0);
        run_event(5, 20'h00042, 2'b00, 4'hF, 1, 37, 0, -1, 0, 4'h0, 0);
        run_event(1, 20'h00043, 2'b00, 4'hF, 1, -1, 0, -1, 0, 4'h0, 0);

        // randomized events with random backpressure
        for (int k = 0; k < 20; k++) begin
            run_event($urandom_range(0, 5), TW'($urandom),
                      2'($urandom_range(0, 3)), NL'($urandom_range(1, 15)),
                      1, -1, 0, -1, 0, 4'h0, 1);
        end
        chk("d2_ev", {112'h0, d2_ev}, {112'h0, m_ev});
        chk("d2_idle", {127'h0, d2_busy}, 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
